// File: rtl/if_prefetch_pkg.sv
// Shared types and defaults for the instruction prefetch stage.
// The reset PC default is the same constant the trap/vector logic uses.
package if_prefetch_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned MEM_SIZE_DEFAULT = 'h0000_1000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Depth-entry synchronous FIFO of {word, pc} pairs; flush beats push/pop.
// When empty the head shows the most recently written slot so it stays stable.
module fetch_fifo
  import if_prefetch_pkg::*;
#(
  parameter int unsigned Depth   = 2,
  parameter int unsigned PcWidth = 12,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned CntW   = $clog2(Depth + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  word_t              push_word,
  input  logic [PcWidth-1:0] push_pc,
  input  logic               pop,
  output word_t              head_word,
  output logic [PcWidth-1:0] head_pc,
  output logic [CntW-1:0]    count,
  output logic               full,
  output logic               empty
);

  word_t              mem_word [Depth];
  logic [PcWidth-1:0] mem_pc   [Depth];
  logic [PtrW-1:0]    rd_ptr;
  logic [PtrW-1:0]    wr_ptr;
  logic [PtrW-1:0]    head_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_word[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem_word[wr_ptr] <= push_word;
        mem_pc[wr_ptr]   <= push_pc;
        wr_ptr           <= wr_ptr + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Empty: point at the slot just behind the write pointer (last written).
  assign head_ptr  = empty ? (wr_ptr - PtrW'(1)) : rd_ptr;
  assign head_word = mem_word[head_ptr];
  assign head_pc   = mem_pc[head_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch: owns fetch_pc, drives the ROM address, queues
// {word, pc} for decode, and flushes/re-steers on redirect.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned  MemSize = MEM_SIZE_DEFAULT,
  parameter int unsigned  Depth   = 2,
  parameter logic [31:0]  ResetPc = RESET_PC_DEFAULT,
  localparam int unsigned MemAddrWidth = $clog2(MemSize),
  localparam int unsigned CntW         = $clog2(Depth + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [MemAddrWidth-1:0] rom_addr,
  input  word_t                   rom_data,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  output logic                    instr_valid,
  output word_t                   instr,
  output logic [31:0]             instr_pc,
  input  logic                    instr_ready
);

  logic [MemAddrWidth-1:0] fetch_pc;
  logic [MemAddrWidth-1:0] redirect_target;
  logic [MemAddrWidth-1:0] head_pc;
  logic [CntW-1:0]         count;
  logic                    full;
  logic                    empty;
  logic                    pop;
  logic                    push;
  logic                    unused_pc_bits;

  assign pop  = instr_valid & instr_ready;
  assign push = ~redirect_valid & (~full | pop);

  // Misaligned and out-of-range redirect targets are masked, not reported.
  assign redirect_target = {redirect_pc[MemAddrWidth-1:2], 2'b00};
  assign unused_pc_bits  = ^{redirect_pc[31:MemAddrWidth], redirect_pc[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= ResetPc[MemAddrWidth-1:0];
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
    end else if (push) begin
      fetch_pc <= fetch_pc + MemAddrWidth'(4);
    end
  end

  assign rom_addr = fetch_pc;

  fetch_fifo #(
    .Depth   (Depth),
    .PcWidth (MemAddrWidth)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_word (rom_data),
    .push_pc   (fetch_pc),
    .pop       (pop),
    .head_word (instr),
    .head_pc   (head_pc),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign instr_valid = ~empty;
  assign instr_pc    = 32'(head_pc);

  a_pop_nonempty: assert property (@(posedge clk) disable iff (reset)
    pop |-> (count != '0));

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: queue-based reference model compared every cycle,
// directed scenarios pinned with literal expectations, then random traffic.
module tb_if_prefetch;
  import if_prefetch_pkg::*;

  localparam int unsigned MEM_SIZE = 'h1000;
  localparam int unsigned DEPTH    = 2;
  localparam int unsigned AW       = 12;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          instr_ready = 1'b0;
  logic [AW-1:0] rom_addr;
  word_t         rom_data;
  logic          instr_valid;
  word_t         instr;
  logic [31:0]   instr_pc;
  logic [31:0]   salt = '0;

  int checks = 0;
  int errors = 0;

  logic [63:0]   mq[$];
  logic [AW-1:0] m_pc;
  logic          m_zero_head;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(logic [AW-1:0] a);
    return {22'b0, a[AW-1:2]} ^ salt;
  endfunction

  assign rom_data = rom_word(rom_addr);

  if_prefetch #(
    .MemSize (MEM_SIZE),
    .Depth   (DEPTH),
    .ResetPc (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock cycle: compare outputs with the model, drive inputs, advance the model.
  task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic do_pop;
    logic space;
    @(negedge clk);
    chk("rom_addr", 32'(rom_addr), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("instr", instr, mq[0][63:32]);
      chk("instr_pc", instr_pc, mq[0][31:0]);
    end else if (m_zero_head) begin
      chk("instr_reset", instr, 32'h0);
      chk("instr_pc_reset", instr_pc, 32'h0);
    end
    reset          = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    if (r) begin
      mq.delete();
      m_pc        = RESET_PC[AW-1:0];
      m_zero_head = 1'b1;
    end else begin
      do_pop = (mq.size() != 0) && rdy;
      space  = (mq.size() < DEPTH) || do_pop;
      if (do_pop) void'(mq.pop_front());
      if (rv) begin
        mq.delete();
        m_pc = rpc[AW-1:0] & ~AW'(3);
      end else if (space) begin
        mq.push_back({rom_word(m_pc), 32'(m_pc)});
        m_pc        = m_pc + AW'(4);
        m_zero_head = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    mq.delete();
    m_pc        = RESET_PC[AW-1:0];
    m_zero_head = 1'b1;

    // Startup streaming: words k at address 4k.
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("lit_reset_valid", 32'(instr_valid), 32'h0);
    chk("lit_reset_addr", 32'(rom_addr), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("lit_stream_pc", instr_pc, 32'(4 * (k - 1)));
      chk("lit_stream_word", instr, 32'(k - 1));
    end

    // Stall with full FIFO, then resume.
    do_reset();
    for (int k = 0; k <= 13; k++) begin
      cycle(1'b0, 1'b0, 32'h0, k >= 10);
      if (k == 9) begin
        chk("lit_stall_addr", 32'(rom_addr), 32'h8);
        chk("lit_stall_pc", instr_pc, 32'h0);
        chk("lit_stall_valid", 32'(instr_valid), 32'h1);
      end
      if (k >= 10) chk("lit_resume_pc", instr_pc, 32'(4 * (k - 10)));
    end

    // Redirect while streaming.
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      cycle(1'b0, k == 5, 32'h40, 1'b1);
      if (k == 6) chk("lit_redir_bubble", 32'(instr_valid), 32'h0);
      if (k == 7) chk("lit_redir_target", instr_pc, 32'h40);
      if (k == 8) chk("lit_redir_next", instr_pc, 32'h44);
    end

    // Out-of-range, misaligned redirect wraps at MemSize.
    do_reset();
    cycle(1'b0, 1'b1, 32'h0000_1FFE, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("lit_wrap_addr", 32'(rom_addr), 32'hFFC);
    chk("lit_wrap_bubble", 32'(instr_valid), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("lit_wrap_pc0", instr_pc, 32'hFFC);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("lit_wrap_pc1", instr_pc, 32'h0);

    // Redirect together with a pop of the full FIFO.
    do_reset();
    for (int k = 0; k <= 6; k++) begin
      cycle(1'b0, k == 4, 32'h80, k >= 4);
      if (k == 4) chk("lit_full_before", 32'(instr_valid), 32'h1);
      if (k == 5) chk("lit_full_flushed", 32'(instr_valid), 32'h0);
      if (k == 6) chk("lit_full_target", instr_pc, 32'h80);
    end

    // Reset mid-stream overrides a simultaneous redirect and handshake.
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h200, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("lit_midreset_valid", 32'(instr_valid), 32'h0);
    chk("lit_midreset_addr", 32'(rom_addr), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("lit_midreset_pc", instr_pc, 32'h0);

    // Random traffic with a different ROM image; salt changes only under reset.
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    salt = $urandom();
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 19) == 0,
            $urandom(),
            $urandom_range(0, 9) < 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Instruction prefetch stage sitting directly downstream of the instruction ROM and upstream of decode. It owns the fetch PC, drives the ROM's combinational word address, and captures returned instruction words with their PCs into a small FIFO. It presents them to decode over a valid/ready handshake and flushes and re-steers on a redirect from branch, jump or interrupt logic.

## Interface
- MemSize, 'h0000_1000, ROM size in bytes; must match the ROM instance
- MemAddrWidth, $clog2(MemSize), derived (localparam); byte address width
- Depth, 2, FIFO entries; power of two, 2..8
- ResetPc, 'h0000_0000, fetch PC after reset; word aligned, < MemSize
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rom_addr  out  MemAddrWidth  byte address to ROM; bits [1:0] always 0
- rom_data  in  32  ROM word for rom_addr, combinational, same cycle
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new PC; bits [1:0] ignored; bits above MemAddrWidth ignored
- instr_valid  out  1  FIFO head holds a valid instruction
- instr  out  32  FIFO head instruction word
- instr_pc  out  32  byte PC of instr, zero-extended from MemAddrWidth
- instr_ready  in  1  decode accepts head this cycle

## Operation
- State: fetch_pc (MemAddrWidth bits, bits [1:0] zero), FIFO of Depth entries {word, pc}, read/write pointers, occupancy count (0..Depth).
- rom_addr = fetch_pc at all times, registered, with no combinational path from redirect inputs.
- pop = instr_valid & instr_ready.
- push = !redirect_valid & (count < Depth | pop). Pushes {rom_data, fetch_pc}, then fetch_pc += 4 with natural wrap at MemSize, so MemSize-4 is followed by 0.
- Full with no pop: no push, and fetch_pc holds.
- Full with pop in the same cycle: push and pop both occur, and count is unchanged.
- Empty: instr_valid = 0. instr and instr_pc are don't-care but must be stable (show the last written slot).
- redirect_valid = 1: count and pointers clear to 0, fetch_pc <= {redirect_pc[MemAddrWidth-1:2], 2'b00}, and no push. The ROM word read this cycle is discarded.
- redirect_valid together with a pop: decode's handshake is honoured (head counts as consumed), then the flush applies. Redirect has priority over everything except reset.
- Back-to-back redirects: each cycle's redirect wins. Only the last one's PC is fetched.
- No instruction interpretation. Misaligned or out-of-range redirect PCs are silently masked.

## Timing
- Reset values: fetch_pc = ResetPc, count = 0, pointers = 0, instr_valid = 0, rom_addr = ResetPc, instr = 0, instr_pc = 0.
- Reset asserted mid-operation overrides redirect and handshakes. The state above holds from the next edge.
- Startup: reset low in cycle 0 pushes ResetPc at the end of cycle 0, so instr_valid = 1 in cycle 1.
- Redirect latency: redirect in cycle N, new fetch_pc in cycle N+1, pushed at end of N+1, so instr_valid with instr_pc = target in cycle N+2. instr_valid = 0 in cycle N+1.
- Steady state with instr_ready held high: one instruction per cycle, consecutive PCs, no bubbles.
- instr, instr_pc and instr_valid are driven from registers only (FIFO head), with no combinational path from instr_ready.
- instr_ready may change freely while instr_valid = 0. The head is stable while instr_valid & !instr_ready.

## Structure
- mem_pkg: reuse the word typedef for instruction storage.
- config_pkg: ResetPc default constant shared with the core's trap/vector logic.
- One sub-module, fetch_fifo: a parameterised Depth-entry synchronous FIFO of {word, pc} with push, pop, flush, count, full and empty, and flush having priority.
- if_prefetch holds fetch_pc, the push/redirect control, and the fetch_fifo instance.

## Test plan
- Reset with ResetPc = 0, ROM words k at address 4k, instr_ready = 1 -> cycles 1..6 give instr_pc 0,4,8,..,20 and instr 0..5, with no gaps.
- instr_ready = 0 for 10 cycles after reset, Depth = 2 -> count saturates at 2, rom_addr stops at 8, and the head stays (pc 0) unchanged. Raising instr_ready resumes 0,4,8,12 with none lost or duplicated.
- Redirect to 'h40 in cycle 5 while streaming -> instr_valid = 0 in cycle 6, then instr_pc = 'h40 in cycle 7 and 'h44 in cycle 8. No pre-redirect PC appears after cycle 5.
- Redirect to 'h0000_1FFE with MemSize 'h1000 -> fetch resumes at 'hFFC, then wraps to 0.
- Redirect asserted the same cycle as a pop of the full FIFO -> that pop counts, both entries are flushed, and the target arrives 2 cycles later. Reset asserted mid-stream -> instr_valid = 0 next cycle and the stream restarts at ResetPc.
